// File: rtl/adder_4bit_if.sv
// rtl/adder_4bit_if.sv - operand/result bundle for the 4-bit adder
interface adder_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic [3:0] sum;
  logic       cout;
  logic [3:0] sum_q;
  logic       cout_q;
  logic       ovf_q;
  logic       zero_q;
  logic       out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, sum_q, cout_q, ovf_q, zero_q, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, sum_q, cout_q, ovf_q, zero_q, out_valid
  );
endinterface

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - ripple-carry adder with live result and registered flag-annotated copy
module adder_4bit (
  input  logic        clk,
  input  logic        rst_n,
  adder_4bit_if.slave bus
);

  logic [4:0] c;
  logic [3:0] s;
  logic       ovf;
  logic       zero;

  // c[i] is the carry into bit i; c[3]^c[4] exposes signed overflow directly
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = bus.cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
      c[i+1] = (bus.a[i] & bus.b[i]) | ((bus.a[i] ^ bus.b[i]) & c[i]);
    end
  end

  assign ovf      = c[3] ^ c[4];
  assign zero     = (s == 4'b0000);
  assign bus.sum  = s;
  assign bus.cout = c[4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sum_q     <= 4'b0000;
      bus.cout_q    <= 1'b0;
      bus.ovf_q     <= 1'b0;
      bus.zero_q    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum_q  <= s;
        bus.cout_q <= c[4];
        bus.ovf_q  <= ovf;
        bus.zero_q <= zero;
      end
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - directed and exhaustive self-checking bench for adder_4bit
module tb_adder_4bit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  adder_4bit_if bus ();

  adder_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, " sum_q"},     {4'b0, bus.sum_q},     8'h00);
    check({tag, " cout_q"},    {7'b0, bus.cout_q},    8'h00);
    check({tag, " ovf_q"},     {7'b0, bus.ovf_q},     8'h00);
    check({tag, " zero_q"},    {7'b0, bus.zero_q},    8'h00);
    check({tag, " out_valid"}, {7'b0, bus.out_valid}, 8'h00);
  endtask

  // {a, b, cin, sum, cout, ovf, zero}
  logic [15:0] vec [7];

  initial begin
    logic [15:0] v;
    logic [4:0]  full;
    logic [3:0]  es;
    logic        eo;

    vec[0] = {4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
    vec[1] = {4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0};
    vec[2] = {4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
    vec[3] = {4'h7, 4'h1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0};
    vec[4] = {4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
    vec[5] = {4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vec[6] = {4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.a = 4'h0; bus.b = 4'h0; bus.cin = 1'b0; bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_regs_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v = vec[i];
      @(negedge clk);
      bus.a = v[15:12]; bus.b = v[11:8]; bus.cin = v[7]; bus.in_valid = 1'b1;
      #1;
      check($sformatf("v%0d sum", i),  {4'b0, bus.sum},  {4'b0, v[6:3]});
      check($sformatf("v%0d cout", i), {7'b0, bus.cout}, {7'b0, v[2]});
      @(posedge clk);
      #1;
      check($sformatf("v%0d sum_q", i),     {4'b0, bus.sum_q},     {4'b0, v[6:3]});
      check($sformatf("v%0d cout_q", i),    {7'b0, bus.cout_q},    {7'b0, v[2]});
      check($sformatf("v%0d ovf_q", i),     {7'b0, bus.ovf_q},     {7'b0, v[1]});
      check($sformatf("v%0d zero_q", i),    {7'b0, bus.zero_q},    {7'b0, v[0]});
      check($sformatf("v%0d out_valid", i), {7'b0, bus.out_valid}, 8'h01);
    end

    // hold: last capture was 8+8 -> sum 0, cout 1, ovf 1, zero 1
    @(negedge clk);
    bus.a = 4'h3; bus.b = 4'h4; bus.cin = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold sum_q",     {4'b0, bus.sum_q},     8'h00);
    check("hold cout_q",    {7'b0, bus.cout_q},    8'h01);
    check("hold ovf_q",     {7'b0, bus.ovf_q},     8'h01);
    check("hold zero_q",    {7'b0, bus.zero_q},    8'h01);
    check("hold out_valid", {7'b0, bus.out_valid}, 8'h00);
    check("hold sum live",  {4'b0, bus.sum},       8'h07);

    // reset overrides in_valid; combinational path stays live
    @(negedge clk);
    rst_n = 1'b0;
    bus.a = 4'hF; bus.b = 4'hF; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_regs_zero("rst mid");
    check("rst sum live",  {4'b0, bus.sum},  8'h0F);
    check("rst cout live", {7'b0, bus.cout}, 8'h01);
    @(negedge clk);
    bus.a = 4'h2; bus.b = 4'h9; bus.cin = 1'b0;
    #1;
    check("rst sum track", {4'b0, bus.sum}, 8'h0B);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      bus.a = k[8:5]; bus.b = k[4:1]; bus.cin = k[0]; bus.in_valid = 1'b1;
      full = {1'b0, k[8:5]} + {1'b0, k[4:1]} + {4'b0, k[0]};
      es   = full[3:0];
      eo   = (k[8] == k[4]) && (es[3] != k[8]);
      #1;
      check($sformatf("sw%0d comb", k), {3'b0, bus.cout, bus.sum}, {3'b0, full});
      @(posedge clk);
      #1;
      check($sformatf("sw%0d reg", k), {3'b0, bus.cout_q, bus.sum_q}, {3'b0, full});
      check($sformatf("sw%0d ovf_q", k), {7'b0, bus.ovf_q}, {7'b0, eo});
      check($sformatf("sw%0d zero_q", k), {7'b0, bus.zero_q}, {7'b0, es == 4'b0000});
      check($sformatf("sw%0d out_valid", k), {7'b0, bus.out_valid}, 8'h01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
